// File: rtl/vend_change_ctrl.sv
// Vending change controller: accumulates coin credit, vends against a latched price
// and pays change back one greedy coin at a time through a shared external subtractor.
//
// state  | meaning
// IDLE   | accepting coins, select or cancel
// CHECK  | compare credit against latched price
// VEND   | one-cycle product release, credit reduced by price
// CHANGE | presenting change coins until credit reaches zero
module vend_change_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_valid,
   input  logic [1:0] coin_val,
   input  logic       sel_valid,
   input  logic [3:0] price,
   input  logic       cancel,
   input  logic       change_ack,
   output logic [3:0] sub_a,
   output logic [3:0] sub_b,
   input  logic [3:0] sub_diff,
   input  logic       sub_cout,
   output logic [3:0] credit,
   output logic       dispense,
   output logic       change_valid,
   output logic [1:0] change_coin,
   output logic       coin_reject,
   output logic       short_pay,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, CHECK, VEND, CHANGE} state_t;

   state_t     state;
   logic [3:0] price_q;
   logic [3:0] coin_amt;
   logic [4:0] coin_sum;
   logic       coin_ok;

   function automatic logic [3:0] coin_value(input logic [1:0] c);
      case (c)
         2'b00:   coin_value = 4'd1;
         2'b01:   coin_value = 4'd2;
         2'b10:   coin_value = 4'd5;
         default: coin_value = 4'd0;
      endcase
   endfunction

   function automatic logic [1:0] greedy(input logic [3:0] c);
      if (c >= 4'd5)      greedy = 2'b10;
      else if (c >= 4'd2) greedy = 2'b01;
      else                greedy = 2'b00;
   endfunction

   assign coin_amt = coin_value(coin_val);
   assign coin_sum = {1'b0, credit} + {1'b0, coin_amt};
   assign coin_ok  = (coin_val != 2'b11) && (coin_sum <= 5'd15);
   assign busy     = (state != IDLE);

   always_comb begin
      sub_a = credit;
      sub_b = 4'd0;
      case (state)
         CHECK, VEND: sub_b = price_q;
         CHANGE:      sub_b = coin_value(change_coin);
         default:     sub_b = 4'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         credit       <= 4'd0;
         price_q      <= 4'd0;
         dispense     <= 1'b0;
         change_valid <= 1'b0;
         change_coin  <= 2'b00;
         coin_reject  <= 1'b0;
         short_pay    <= 1'b0;
      end else begin
         dispense    <= 1'b0;
         short_pay   <= 1'b0;
         // Any coin not credited this edge is bounced, whatever the state.
         coin_reject <= coin_valid && ((state != IDLE) || cancel || !coin_ok);
         case (state)
            IDLE: begin
               if (cancel) begin
                  if (credit != 4'd0) begin
                     state        <= CHANGE;
                     change_valid <= 1'b1;
                     change_coin  <= greedy(credit);
                  end
               end else if (coin_valid) begin
                  if (coin_ok) credit <= coin_sum[3:0];
               end else if (sel_valid) begin
                  price_q <= price;
                  state   <= CHECK;
               end
            end
            CHECK: begin
               if (sub_cout) begin
                  state    <= VEND;
                  dispense <= 1'b1;
               end else begin
                  state     <= IDLE;
                  short_pay <= 1'b1;
               end
            end
            VEND: begin
               credit <= sub_diff;
               if (sub_diff != 4'd0) begin
                  state        <= CHANGE;
                  change_valid <= 1'b1;
                  change_coin  <= greedy(sub_diff);
               end else begin
                  state <= IDLE;
               end
            end
            CHANGE: begin
               if (change_ack) begin
                  credit <= sub_diff;
                  if (sub_diff == 4'd0) begin
                     state        <= IDLE;
                     change_valid <= 1'b0;
                     change_coin  <= 2'b00;
                  end else begin
                     change_coin <= greedy(sub_diff);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Directed bench for vend_change_ctrl; models the external 4-bit subtractor.
module tb_vend_change_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       coin_valid;
   logic [1:0] coin_val;
   logic       sel_valid;
   logic [3:0] price;
   logic       cancel;
   logic       change_ack;
   logic [3:0] sub_a, sub_b, sub_diff;
   logic       sub_cout;
   logic [3:0] credit;
   logic       dispense, change_valid, coin_reject, short_pay, busy;
   logic [1:0] change_coin;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign sub_diff = sub_a - sub_b;
   assign sub_cout = (sub_a >= sub_b);

   vend_change_ctrl dut (
      .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
      .sel_valid(sel_valid), .price(price), .cancel(cancel), .change_ack(change_ack),
      .sub_a(sub_a), .sub_b(sub_b), .sub_diff(sub_diff), .sub_cout(sub_cout),
      .credit(credit), .dispense(dispense), .change_valid(change_valid),
      .change_coin(change_coin), .coin_reject(coin_reject), .short_pay(short_pay),
      .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      coin_valid = 1'b0; coin_val = 2'b00; sel_valid = 1'b0; price = 4'd0;
      cancel = 1'b0; change_ack = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic insert(input logic [1:0] c);
      coin_valid = 1'b1; coin_val = c;
      tick();
      coin_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (credit !== 4'd0) begin bad++; $display("FAIL reset_credit got=%0d exp=0", credit); end
      total++; if (busy !== 1'b0 || change_valid !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b/%b exp=0/0", busy, change_valid); end
      total++; if (change_coin !== 2'b00 || dispense !== 1'b0) begin bad++; $display("FAIL reset_coin got=%b/%b exp=00/0", change_coin, dispense); end
      total++; if (sub_a !== 4'd0 || sub_b !== 4'd0) begin bad++; $display("FAIL reset_sub got=%0d/%0d exp=0/0", sub_a, sub_b); end
      insert(2'b11);
      total++; if (coin_reject !== 1'b1 || credit !== 4'd0) begin bad++; $display("FAIL invalid_coin got rej=%b cr=%0d exp=1/0", coin_reject, credit); end
   endtask

   task automatic test_vend_change();
      do_reset();
      insert(2'b10); insert(2'b01); insert(2'b00);
      total++; if (credit !== 4'd8) begin bad++; $display("FAIL coins_sum got=%0d exp=8", credit); end
      total++; if (sub_a !== 4'd8 || sub_b !== 4'd0) begin bad++; $display("FAIL idle_sub got=%0d/%0d exp=8/0", sub_a, sub_b); end
      sel_valid = 1'b1; price = 4'd6;
      tick();                        // edge N
      sel_valid = 1'b0; price = 4'd0;
      total++; if (busy !== 1'b1 || dispense !== 1'b0) begin bad++; $display("FAIL check_state got busy=%b disp=%b exp=1/0", busy, dispense); end
      total++; if (sub_b !== 4'd6) begin bad++; $display("FAIL check_price got=%0d exp=6", sub_b); end
      tick();                        // cycle N+2
      total++; if (dispense !== 1'b1 || change_valid !== 1'b0) begin bad++; $display("FAIL vend_cycle got disp=%b cv=%b exp=1/0", dispense, change_valid); end
      tick();                        // cycle N+3
      total++; if (dispense !== 1'b0 || change_valid !== 1'b1 || change_coin !== 2'b01) begin bad++; $display("FAIL first_change got disp=%b cv=%b coin=%b exp=0/1/01", dispense, change_valid, change_coin); end
      total++; if (credit !== 4'd2) begin bad++; $display("FAIL vend_credit got=%0d exp=2", credit); end
      change_ack = 1'b1;
      tick();
      change_ack = 1'b0;
      total++; if (credit !== 4'd0 || change_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL change_done got cr=%0d cv=%b busy=%b exp=0/0/0", credit, change_valid, busy); end
   endtask

   task automatic test_short_pay();
      do_reset();
      insert(2'b01); insert(2'b00);
      sel_valid = 1'b1; price = 4'd7;
      tick();
      sel_valid = 1'b0;
      tick();
      total++; if (short_pay !== 1'b1 || dispense !== 1'b0) begin bad++; $display("FAIL short_pay got sp=%b disp=%b exp=1/0", short_pay, dispense); end
      total++; if (credit !== 4'd3 || busy !== 1'b0) begin bad++; $display("FAIL short_credit got cr=%0d busy=%b exp=3/0", credit, busy); end
      tick();
      total++; if (short_pay !== 1'b0) begin bad++; $display("FAIL short_pulse got=%b exp=0", short_pay); end
   endtask

   task automatic test_overflow();
      do_reset();
      insert(2'b10); insert(2'b10); insert(2'b01); insert(2'b01);
      total++; if (credit !== 4'd14) begin bad++; $display("FAIL credit14 got=%0d exp=14", credit); end
      insert(2'b01);
      total++; if (coin_reject !== 1'b1 || credit !== 4'd14) begin bad++; $display("FAIL overflow_rej got rej=%b cr=%0d exp=1/14", coin_reject, credit); end
      insert(2'b00);
      total++; if (coin_reject !== 1'b0 || credit !== 4'd15) begin bad++; $display("FAIL fill15 got rej=%b cr=%0d exp=0/15", coin_reject, credit); end
   endtask

   task automatic test_cancel_hold();
      logic [1:0] exp_coin [4];
      logic [3:0] exp_cr   [4];
      exp_coin = '{2'b10, 2'b10, 2'b01, 2'b00};
      exp_cr   = '{4'd8, 4'd3, 4'd1, 4'd0};
      do_reset();
      insert(2'b10); insert(2'b10); insert(2'b01); insert(2'b00);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (change_valid !== 1'b1 || change_coin !== 2'b10 || credit !== 4'd13) begin
            bad++; $display("FAIL hold_%0d got cv=%b coin=%b cr=%0d exp=1/10/13", i, change_valid, change_coin, credit);
         end
         tick();
      end
      change_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (change_coin !== exp_coin[i]) begin bad++; $display("FAIL refund_coin_%0d got=%b exp=%b", i, change_coin, exp_coin[i]); end
         tick();
         total++;
         if (credit !== exp_cr[i]) begin bad++; $display("FAIL refund_credit_%0d got=%0d exp=%0d", i, credit, exp_cr[i]); end
      end
      change_ack = 1'b0;
      total++; if (change_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL refund_end got cv=%b busy=%b exp=0/0", change_valid, busy); end
   endtask

   task automatic test_priority();
      do_reset();
      insert(2'b01); insert(2'b01);
      cancel = 1'b1; coin_valid = 1'b1; coin_val = 2'b00; sel_valid = 1'b1; price = 4'd3;
      tick();
      cancel = 1'b0; coin_valid = 1'b0; sel_valid = 1'b0;
      total++; if (change_valid !== 1'b1 || coin_reject !== 1'b1) begin bad++; $display("FAIL prio_cancel got cv=%b rej=%b exp=1/1", change_valid, coin_reject); end
      total++; if (credit !== 4'd4 || change_coin !== 2'b01 || sub_b !== 4'd2) begin bad++; $display("FAIL prio_coin got cr=%0d coin=%b subb=%0d exp=4/01/2", credit, change_coin, sub_b); end
      coin_valid = 1'b1; coin_val = 2'b10; sel_valid = 1'b1; cancel = 1'b1;
      tick();
      coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
      total++; if (coin_reject !== 1'b1 || credit !== 4'd4 || change_coin !== 2'b01) begin bad++; $display("FAIL busy_coin got rej=%b cr=%0d coin=%b exp=1/4/01", coin_reject, credit, change_coin); end
      change_ack = 1'b1;
      tick(); tick();
      change_ack = 1'b0;
      total++; if (credit !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL prio_end got cr=%0d busy=%b exp=0/0", credit, busy); end
      insert(2'b10);
      change_ack = 1'b1;
      tick();
      change_ack = 1'b0;
      total++; if (credit !== 4'd5 || change_valid !== 1'b0) begin bad++; $display("FAIL idle_ack got cr=%0d cv=%b exp=5/0", credit, change_valid); end
   endtask

   task automatic test_zero_price();
      do_reset();
      insert(2'b01); insert(2'b00);
      sel_valid = 1'b1; price = 4'd0;
      tick();
      sel_valid = 1'b0;
      tick();
      total++; if (dispense !== 1'b1) begin bad++; $display("FAIL zero_price_disp got=%b exp=1", dispense); end
      tick();
      total++; if (credit !== 4'd3 || change_coin !== 2'b01 || change_valid !== 1'b1) begin bad++; $display("FAIL zero_price_change got cr=%0d coin=%b cv=%b exp=3/01/1", credit, change_coin, change_valid); end
      change_ack = 1'b1;
      tick();
      total++; if (credit !== 4'd1 || change_coin !== 2'b00) begin bad++; $display("FAIL zero_price_last got cr=%0d coin=%b exp=1/00", credit, change_coin); end
      tick();
      change_ack = 1'b0;
      total++; if (credit !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL zero_price_end got cr=%0d busy=%b exp=0/0", credit, busy); end
   endtask

   task automatic test_reset_mid_change();
      do_reset();
      insert(2'b10); insert(2'b01);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      total++; if (change_valid !== 1'b1 || credit !== 4'd7) begin bad++; $display("FAIL pre_rst got cv=%b cr=%0d exp=1/7", change_valid, credit); end
      rst = 1'b1; change_ack = 1'b1;
      tick();
      rst = 1'b0; change_ack = 1'b0;
      total++; if (change_valid !== 1'b0 || credit !== 4'd0 || busy !== 1'b0 || change_coin !== 2'b00) begin bad++; $display("FAIL mid_rst got cv=%b cr=%0d busy=%b coin=%b exp=0/0/0/00", change_valid, credit, busy, change_coin); end
   endtask

   initial begin
      test_reset();
      test_vend_change();
      test_short_pay();
      test_overflow();
      test_cancel_hold();
      test_priority();
      test_zero_price();
      test_reset_mid_change();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
